// File: rtl/dcache_controller_if.sv
// Shared size encoding plus the two bus interfaces of the data cache controller:
// the LSU request/response port and the memory bus.
package dcache_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memory_operation_size_e;
endpackage

// LSU side: master = load/store unit, slave = cache controller.
interface dcache_lsu_if #(parameter int XLEN = 32);
    logic                               req_valid;
    logic                               req_ready;
    logic [XLEN-1:0]                    req_addr;
    logic                               req_write;
    dcache_pkg::memory_operation_size_e req_size;
    logic [XLEN-1:0]                    req_wdata;
    logic                               rsp_valid;
    logic [XLEN-1:0]                    rsp_rdata;

    modport master (
        output req_valid, req_addr, req_write, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_addr, req_write, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// Memory side: master = cache controller, slave = memory.
interface dcache_mem_if #(parameter int XLEN = 32);
    logic                               req_valid;
    logic                               req_ready;
    logic [XLEN-1:0]                    req_addr;
    logic                               req_write;
    dcache_pkg::memory_operation_size_e req_size;
    logic [XLEN-1:0]                    req_wdata;
    logic                               rsp_valid;
    logic [XLEN-1:0]                    rsp_rdata;

    modport master (
        output req_valid, req_addr, req_write, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_addr, req_write, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Owns the tag/valid array, performs hit/miss lookup, fills a missing line
// one word at a time from memory and steers every datalines control input.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int NUM_SETS         = 4,
    parameter int SET_SIZE         = 2,
    parameter int WORDS_PER_LINE   = 8,
    parameter int WORD_SELECT_SIZE = 3,
    parameter int BYTE_SELECT_SIZE = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    dcache_lsu_if.slave                 lsu,
    dcache_mem_if.master                mem,
    output logic                        dl_perform_write,
    output logic [SET_SIZE-1:0]         dl_set,
    output memory_operation_size_e      dl_op_size,
    output logic [WORD_SELECT_SIZE-1:0] dl_word_select,
    output logic [BYTE_SELECT_SIZE-1:0] dl_byte_select,
    output logic [XLEN-1:0]             dl_word_to_store,
    input  logic [XLEN-1:0]             dl_fetched_word
);

    localparam int TAG_SIZE = XLEN - SET_SIZE - WORD_SELECT_SIZE - BYTE_SELECT_SIZE;
    localparam logic [WORD_SELECT_SIZE-1:0] LAST_WORD = WORD_SELECT_SIZE'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_WRITE_MEM
    } state_e;

    state_e                              state_q, state_d;
    logic [XLEN-1:0]                     req_addr_q, req_addr_d;
    logic                                req_write_q, req_write_d;
    memory_operation_size_e              req_size_q, req_size_d;
    logic [XLEN-1:0]                     req_wdata_q, req_wdata_d;
    logic [WORD_SELECT_SIZE-1:0]         cnt_q, cnt_d;
    logic [NUM_SETS-1:0]                 valid_q, valid_d;
    logic [NUM_SETS-1:0][TAG_SIZE-1:0]   tag_q, tag_d;

    // Address fields of the registered request: {tag, set, word, byte}.
    logic [TAG_SIZE-1:0]         req_tag;
    logic [SET_SIZE-1:0]         req_set;
    logic [WORD_SELECT_SIZE-1:0] req_word;
    logic [BYTE_SELECT_SIZE-1:0] req_byte;
    logic                        hit;

    assign req_tag  = req_addr_q[XLEN-1 -: TAG_SIZE];
    assign req_set  = req_addr_q[BYTE_SELECT_SIZE + WORD_SELECT_SIZE +: SET_SIZE];
    assign req_word = req_addr_q[BYTE_SELECT_SIZE +: WORD_SELECT_SIZE];
    assign req_byte = req_addr_q[BYTE_SELECT_SIZE-1:0];
    assign hit      = valid_q[req_set] && (tag_q[req_set] == req_tag);

    // State, request register, fill counter and tag/valid array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_size_q  <= WORD;
            req_wdata_q <= '0;
            cnt_q       <= '0;
            valid_q     <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_write_q <= req_write_d;
            req_size_q  <= req_size_d;
            req_wdata_q <= req_wdata_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
        end
    end

    // Next-state logic plus all LSU, memory and datalines outputs.
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_write_d = req_write_q;
        req_size_d  = req_size_q;
        req_wdata_d = req_wdata_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        tag_d       = tag_q;

        lsu.req_ready = 1'b0;
        lsu.rsp_valid = 1'b0;
        lsu.rsp_rdata = '0;

        mem.req_valid = 1'b0;
        mem.req_addr  = '0;
        mem.req_write = 1'b0;
        mem.req_size  = WORD;
        mem.req_wdata = '0;

        // Datalines normally follow the request register; the fill states
        // override word select and size to stream whole words in.
        dl_perform_write = 1'b0;
        dl_set           = req_set;
        dl_op_size       = req_size_q;
        dl_word_select   = req_word;
        dl_byte_select   = req_byte;
        dl_word_to_store = req_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                lsu.req_ready = 1'b1;
                if (lsu.req_valid) begin
                    req_addr_d  = lsu.req_addr;
                    req_write_d = lsu.req_write;
                    req_size_d  = lsu.req_size;
                    req_wdata_d = lsu.req_wdata;
                    state_d     = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (req_write_q) begin
                    // No-write-allocate: only a hit updates the line.
                    dl_perform_write = hit;
                    state_d          = S_WRITE_MEM;
                end else if (hit) begin
                    lsu.rsp_valid = 1'b1;
                    lsu.rsp_rdata = dl_fetched_word;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_FILL_REQ;
                end
            end

            S_FILL_REQ: begin
                dl_op_size     = WORD;
                dl_word_select = cnt_q;
                dl_byte_select = '0;
                mem.req_valid  = 1'b1;
                mem.req_addr   = {req_tag, req_set, cnt_q, {BYTE_SELECT_SIZE{1'b0}}};
                mem.req_write  = 1'b0;
                mem.req_size   = WORD;
                if (mem.req_ready) begin
                    state_d = S_FILL_WAIT;
                end
            end

            S_FILL_WAIT: begin
                dl_op_size       = WORD;
                dl_word_select   = cnt_q;
                dl_byte_select   = '0;
                dl_word_to_store = mem.rsp_rdata;
                if (mem.rsp_valid) begin
                    dl_perform_write = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        // Line complete: mark valid and replay the lookup,
                        // which now hits.
                        valid_d[req_set] = 1'b1;
                        tag_d[req_set]   = req_tag;
                        state_d          = S_LOOKUP;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_FILL_REQ;
                    end
                end
            end

            S_WRITE_MEM: begin
                mem.req_valid = 1'b1;
                mem.req_addr  = req_addr_q;
                mem.req_write = 1'b1;
                mem.req_size  = req_size_q;
                mem.req_wdata = req_wdata_q;
                if (mem.req_ready) begin
                    // Writes are posted; completion is the accepted request.
                    lsu.rsp_valid = 1'b1;
                    state_d       = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: behavioural datalines array and a
// one-outstanding-read memory with write-through update.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_lsu_if #(.XLEN(32)) lsu ();
    dcache_mem_if #(.XLEN(32)) mem ();

    logic        dl_perform_write;
    logic [1:0]  dl_set;
    memory_operation_size_e dl_op_size;
    logic [2:0]  dl_word_select;
    logic [1:0]  dl_byte_select;
    logic [31:0] dl_word_to_store;
    logic [31:0] dl_fetched_word;

    dcache_controller dut (
        .clk              (clk),
        .reset            (reset),
        .lsu              (lsu),
        .mem              (mem),
        .dl_perform_write (dl_perform_write),
        .dl_set           (dl_set),
        .dl_op_size       (dl_op_size),
        .dl_word_select   (dl_word_select),
        .dl_byte_select   (dl_byte_select),
        .dl_word_to_store (dl_word_to_store),
        .dl_fetched_word  (dl_fetched_word)
    );

    int total = 0;
    int bad   = 0;

    // Right-aligned data merged into a word at a byte offset.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                          input memory_operation_size_e sz, input logic [31:0] d);
        logic [31:0] m;
        logic [4:0]  sh;
        sh = {off, 3'b000};
        case (sz)
            BYTE:    m = 32'h0000_00FF << sh;
            HALF:    m = 32'h0000_FFFF << sh;
            default: m = 32'hFFFF_FFFF;
        endcase
        return (old & ~m) | ((d << sh) & m);
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input memory_operation_size_e sz);
        logic [31:0] s;
        logic [4:0]  sh;
        sh = {off, 3'b000};
        s  = w >> sh;
        case (sz)
            BYTE:    return s & 32'h0000_00FF;
            HALF:    return s & 32'h0000_FFFF;
            default: return s;
        endcase
    endfunction

    // Datalines model: synchronous write, combinational read.
    logic [31:0] dl_mem [0:31];
    int dl_wr_cnt = 0;
    always @(posedge clk) begin
        if (dl_perform_write) begin
            dl_mem[{dl_set, dl_word_select}] <= merge(dl_mem[{dl_set, dl_word_select}],
                                                     dl_byte_select, dl_op_size, dl_word_to_store);
            dl_wr_cnt <= dl_wr_cnt + 1;
        end
    end
    assign dl_fetched_word = extract(dl_mem[{dl_set, dl_word_select}], dl_byte_select, dl_op_size);

    // Memory model: word array initialised to 0xC0DE0000 | byte address.
    logic [31:0] bmem [0:255];
    logic        mem_ready_en;
    logic        resp_v, stray_v, pend;
    logic [31:0] resp_d, pend_addr;
    int          beats, wr_cnt;
    logic [31:0] last_wr_addr, last_wr_data;
    memory_operation_size_e last_wr_size;
    logic [31:0] rd_log [$];

    assign mem.rsp_valid = resp_v | stray_v;
    assign mem.rsp_rdata = resp_d;

    initial begin
        resp_v = 0; stray_v = 0; pend = 0; resp_d = '0; pend_addr = '0;
        beats = 0; wr_cnt = 0; mem.req_ready = 0;
        last_wr_addr = '0; last_wr_data = '0; last_wr_size = WORD;
        forever begin
            @(negedge clk);
            resp_v = 0;
            if (reset) begin
                pend = 0;
            end else if (pend) begin
                resp_v = 1;
                resp_d = bmem[pend_addr[9:2]];
                pend   = 0;
                beats++;
            end
            mem.req_ready = mem_ready_en;
            if (!reset && mem.req_valid && mem.req_ready) begin
                if (mem.req_write) begin
                    bmem[mem.req_addr[9:2]] = merge(bmem[mem.req_addr[9:2]], mem.req_addr[1:0],
                                                    mem.req_size, mem.req_wdata);
                    wr_cnt++;
                    last_wr_addr = mem.req_addr;
                    last_wr_size = mem.req_size;
                    last_wr_data = mem.req_wdata;
                end else begin
                    pend      = 1;
                    pend_addr = mem.req_addr;
                    rd_log.push_back(mem.req_addr);
                end
            end
        end
    end

    // Issue one request from IDLE and wait (bounded) for its response.
    task automatic do_req(input logic [31:0] a, input logic w, input memory_operation_size_e sz,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat, output bit to);
        @(negedge clk);
        lsu.req_valid = 1; lsu.req_addr = a; lsu.req_write = w;
        lsu.req_size = sz; lsu.req_wdata = wd;
        @(posedge clk);
        #1 lsu.req_valid = 0;
        lat = 0; to = 0; rd = '0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lsu.rsp_valid) begin rd = lsu.rsp_rdata; break; end
            if (lat > 300) begin to = 1; break; end
        end
    endtask

    task automatic test_reset;
        total++; if (lsu.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", lsu.req_ready); end
        total++; if (lsu.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", lsu.rsp_valid); end
        total++; if (mem.req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid got=%b want=0", mem.req_valid); end
        total++; if (dl_perform_write !== 1'b0) begin bad++; $display("FAIL reset_dl_write got=%b want=0", dl_perform_write); end
    endtask

    task automatic test_fill;
        logic [31:0] rd; int lat; bit to;
        rd_log.delete();
        do_req(32'h100, 0, WORD, 0, rd, lat, to);
        total++; if (to || rd !== 32'hC0DE0100) begin bad++; $display("FAIL fill_rdata got=%h want=c0de0100 to=%0d", rd, to); end
        total++; if (rd_log.size() != 8) begin bad++; $display("FAIL fill_beats got=%0d want=8", rd_log.size()); end
        else begin
            total++; if (rd_log[0] !== 32'h100 || rd_log[7] !== 32'h11C)
                begin bad++; $display("FAIL fill_addrs got=%h..%h want=100..11c", rd_log[0], rd_log[7]); end
        end
    endtask

    task automatic test_read_hit;
        logic [31:0] rd; int lat; bit to;
        rd_log.delete();
        do_req(32'h105, 0, BYTE, 0, rd, lat, to);
        total++; if (to || rd !== 32'h0000_0001) begin bad++; $display("FAIL hit_byte got=%h want=00000001", rd); end
        total++; if (lat != 1) begin bad++; $display("FAIL hit_latency got=%0d want=1", lat); end
        total++; if (rd_log.size() != 0) begin bad++; $display("FAIL hit_mem_traffic got=%0d want=0", rd_log.size()); end
    endtask

    task automatic test_store_hit;
        logic [31:0] rd; int lat; bit to; int dl0, w0;
        dl0 = dl_wr_cnt; w0 = wr_cnt;
        do_req(32'h10A, 1, HALF, 32'h0000_BEEF, rd, lat, to);
        total++; if (to || rd !== 32'h0) begin bad++; $display("FAIL st_hit_rsp got=%h want=0 to=%0d", rd, to); end
        total++; if (dl_wr_cnt - dl0 != 1) begin bad++; $display("FAIL st_hit_dl_writes got=%0d want=1", dl_wr_cnt - dl0); end
        total++; if (wr_cnt - w0 != 1 || last_wr_addr !== 32'h10A || last_wr_size !== HALF || last_wr_data !== 32'hBEEF)
            begin bad++; $display("FAIL st_hit_mem got n=%0d a=%h s=%0d d=%h want n=1 a=10a s=1 d=beef",
                                  wr_cnt - w0, last_wr_addr, last_wr_size, last_wr_data); end
        rd_log.delete();
        do_req(32'h108, 0, WORD, 0, rd, lat, to);
        total++; if (to || rd !== 32'hBEEF_0108) begin bad++; $display("FAIL st_hit_readback got=%h want=beef0108", rd); end
        total++; if (rd_log.size() != 0) begin bad++; $display("FAIL st_hit_readback_traffic got=%0d want=0", rd_log.size()); end
    endtask

    task automatic test_store_miss_evict;
        logic [31:0] rd; int lat; bit to; int dl0, w0;
        dl0 = dl_wr_cnt; w0 = wr_cnt;
        do_req(32'h200, 1, WORD, 32'h1234_5678, rd, lat, to);
        total++; if (to || dl_wr_cnt != dl0) begin bad++; $display("FAIL st_miss_dl_writes got=%0d want=0", dl_wr_cnt - dl0); end
        total++; if (wr_cnt - w0 != 1 || last_wr_addr !== 32'h200)
            begin bad++; $display("FAIL st_miss_mem got n=%0d a=%h want n=1 a=200", wr_cnt - w0, last_wr_addr); end
        rd_log.delete();
        do_req(32'h200, 0, WORD, 0, rd, lat, to);
        total++; if (to || rd !== 32'h1234_5678) begin bad++; $display("FAIL miss_fill_rdata got=%h want=12345678", rd); end
        total++; if (rd_log.size() != 8 || rd_log[0] !== 32'h200 || rd_log[rd_log.size()-1] !== 32'h21C)
            begin bad++; $display("FAIL miss_fill_beats got=%0d want 8 beats 200..21c", rd_log.size()); end
        rd_log.delete();
        do_req(32'h100, 0, WORD, 0, rd, lat, to);
        total++; if (to || rd !== 32'hC0DE_0100) begin bad++; $display("FAIL evict_rdata got=%h want=c0de0100", rd); end
        total++; if (rd_log.size() != 8) begin bad++; $display("FAIL evict_refill got=%0d want=8", rd_log.size()); end
        rd_log.delete();
        do_req(32'h108, 0, WORD, 0, rd, lat, to);
        total++; if (to || rd !== 32'hBEEF_0108) begin bad++; $display("FAIL wt_persist got=%h want=beef0108", rd); end
    endtask

    task automatic test_stall;
        int n, dl0; bit ok;
        mem_ready_en = 0;
        rd_log.delete();
        @(negedge clk);
        lsu.req_valid = 1; lsu.req_addr = 32'h0A0; lsu.req_write = 0; lsu.req_size = WORD; lsu.req_wdata = 0;
        @(posedge clk);
        #1 lsu.req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem.req_valid && n < 20);
        dl0 = dl_wr_cnt; ok = 1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (mem.req_valid !== 1'b1 || mem.req_addr !== 32'h0A0 || mem.req_write !== 1'b0 ||
                mem.req_size !== WORD || dl_perform_write !== 1'b0) ok = 0;
        end
        total++; if (!ok || n >= 20) begin bad++; $display("FAIL stall_stable got valid=%b addr=%h want 1 0a0", mem.req_valid, mem.req_addr); end
        total++; if (dl_wr_cnt != dl0) begin bad++; $display("FAIL stall_dl_write got=%0d want=0", dl_wr_cnt - dl0); end
        mem_ready_en = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!lsu.rsp_valid && n < 300);
        total++; if (!lsu.rsp_valid || lsu.rsp_rdata !== 32'hC0DE_00A0)
            begin bad++; $display("FAIL stall_rdata got=%h want=c0de00a0", lsu.rsp_rdata); end
        total++; if (rd_log.size() != 8 || rd_log[0] !== 32'h0A0)
            begin bad++; $display("FAIL stall_beats got=%0d want=8", rd_log.size()); end
    endtask

    task automatic test_reset_mid_fill;
        logic [31:0] rd; int lat; bit to; int n, dl0, b0;
        b0 = beats;
        @(negedge clk);
        lsu.req_valid = 1; lsu.req_addr = 32'h0C0; lsu.req_write = 0; lsu.req_size = WORD; lsu.req_wdata = 0;
        @(posedge clk);
        #1 lsu.req_valid = 0;
        n = 0;
        while (beats - b0 < 3 && n < 100) begin @(negedge clk); n++; end
        total++; if (beats - b0 < 3) begin bad++; $display("FAIL abort_beats got=%0d want=3", beats - b0); end
        @(posedge clk);
        @(negedge clk); #2 reset = 1;
        @(negedge clk); #2 reset = 0;
        @(negedge clk);
        total++; if (lsu.req_ready !== 1'b1 || mem.req_valid !== 1'b0)
            begin bad++; $display("FAIL abort_idle got ready=%b mreq=%b want 1 0", lsu.req_ready, mem.req_valid); end
        dl0 = dl_wr_cnt;
        stray_v = 1;
        @(negedge clk);
        stray_v = 0;
        @(negedge clk);
        total++; if (dl_wr_cnt != dl0 || lsu.req_ready !== 1'b1)
            begin bad++; $display("FAIL stray_rsp got dl_writes=%0d ready=%b want 0 1", dl_wr_cnt - dl0, lsu.req_ready); end
        rd_log.delete();
        do_req(32'h0C0, 0, WORD, 0, rd, lat, to);
        total++; if (to || rd !== 32'hC0DE_00C0) begin bad++; $display("FAIL refill_rdata got=%h want=c0de00c0", rd); end
        total++; if (rd_log.size() != 8 || rd_log[0] !== 32'h0C0)
            begin bad++; $display("FAIL refill_beats got=%0d want=8 from 0c0", rd_log.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = 32'hC0DE_0000 | (i * 4);
        for (int i = 0; i < 32; i++) dl_mem[i] = 32'hDEAD_DEAD;
        reset = 1; mem_ready_en = 1;
        lsu.req_valid = 0; lsu.req_addr = '0; lsu.req_write = 0; lsu.req_size = WORD; lsu.req_wdata = '0;
        repeat (3) @(negedge clk);
        test_reset;
        #2 reset = 0;
        @(negedge clk);
        test_reset;
        test_fill;
        test_read_hit;
        test_store_hit;
        test_store_miss_evict;
        test_stall;
        test_reset_mid_fill;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
